// File: rtl/sprites_pkg.sv
// Shared types and constants for the sprite position controller: sprite
// indices, command encodings, the default scene and the bus packing helper.
package sprites_pkg;

    localparam int NSPRITES = 6;

    localparam logic [2:0] IDX_CURSOR = 3'd0;
    localparam logic [2:0] IDX_ROBO   = 3'd1;
    localparam logic [2:0] IDX_LIXO3  = 3'd2;
    localparam logic [2:0] IDX_LIXO2  = 3'd3;
    localparam logic [2:0] IDX_LIXO1  = 3'd4;
    localparam logic [2:0] IDX_CELULA = 3'd5;

    typedef enum logic [1:0] {
        OP_ABS  = 2'b00,
        OP_STEP = 2'b01,
        OP_HIDE = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    // Column value Grafico never draws; marks a hidden sprite.
    localparam logic [3:0] HIDE_COL = 4'd15;

    typedef struct packed {
        logic [3:0] col;
        logic [2:0] row;
    } pos_t;

    typedef pos_t [NSPRITES-1:0] scene_t;

    typedef struct packed {
        logic [4*NSPRITES-1:0] cols;
        logic [3*NSPRITES-1:0] rows;
    } buses_t;

    // Opening scene of the game, shown after reset.
    function automatic scene_t default_scene();
        scene_t s;
        s[IDX_CURSOR] = '{col: 4'd6,  row: 3'd3};
        s[IDX_ROBO]   = '{col: 4'd1,  row: 3'd6};
        s[IDX_LIXO3]  = '{col: 4'd1,  row: 3'd2};
        s[IDX_LIXO2]  = '{col: 4'd10, row: 3'd5};
        s[IDX_LIXO1]  = '{col: 4'd6,  row: 3'd3};
        s[IDX_CELULA] = '{col: 4'd1,  row: 3'd5};
        return s;
    endfunction

    localparam scene_t DEFAULT_SCENE = default_scene();

    // Sprite i lands in cols[4i+3:4i] and rows[3i+2:3i].
    function automatic buses_t pack_scene(input scene_t s);
        buses_t b;
        for (int i = 0; i < NSPRITES; i++) begin
            b.cols[4*i +: 4] = s[i].col;
            b.rows[3*i +: 3] = s[i].row;
        end
        return b;
    endfunction

endpackage

// File: rtl/passo_sprite.sv
// Next-position rule for one sprite: absolute write, one-cell step with
// edge saturation, hide. Flags every command that leaves the position alone
// because it is illegal or would leave the grid.
module passo_sprite
    import sprites_pkg::*;
#(
    parameter int NCOL = 12,
    parameter int NROW = 8
) (
    input  pos_t       atual,
    input  op_t        op,
    input  logic [3:0] coluna,
    input  logic [2:0] linha,
    output pos_t       proxima,
    output logic       erro
);

    // Compute the next position and the error flag for the current command.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        proxima = atual;
        erro    = 1'b0;
        unique case (op)
            OP_ABS: begin
                if (int'(coluna) >= NCOL || int'(linha) >= NROW) begin
                    erro = 1'b1;
                end else begin
                    proxima = '{col: coluna, row: linha};
                end
            end
            OP_STEP: begin
                if (atual.col == HIDE_COL) begin
                    erro = 1'b1;
                end else begin
                    unique case (dir_t'(coluna[1:0]))
                        DIR_UP: begin
                            if (atual.row == 3'd0) erro = 1'b1;
                            else                   proxima.row = atual.row - 3'd1;
                        end
                        DIR_DOWN: begin
                            if (int'(atual.row) >= NROW - 1) erro = 1'b1;
                            else                             proxima.row = atual.row + 3'd1;
                        end
                        DIR_LEFT: begin
                            if (atual.col == 4'd0) erro = 1'b1;
                            else                   proxima.col = atual.col - 4'd1;
                        end
                        DIR_RIGHT: begin
                            if (int'(atual.col) >= NCOL - 1) erro = 1'b1;
                            else                             proxima.col = atual.col + 4'd1;
                        end
                    endcase
                end
            end
            OP_HIDE: proxima.col = HIDE_COL;
            OP_RSVD: erro = 1'b1;
        endcase
    end

endmodule

// File: rtl/controle_sprites.sv
// Sprite position controller. Commands edit a shadow scene; the shadow is
// copied to the Grafico buses in one step at the start of each vertical
// sync, so a frame never shows a partially updated scene.
module controle_sprites
    import sprites_pkg::*;
#(
    parameter int NCOL = 12,
    parameter int NROW = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        VSync,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [1:0]  CmdOp,
    input  logic [2:0]  CmdIndice,
    input  logic [3:0]  CmdColuna,
    input  logic [2:0]  CmdLinha,
    output logic [23:0] ColunasSprites,
    output logic [17:0] LinhasSprites,
    output logic [7:0]  Quadro,
    output logic        Pendente,
    output logic        Erro
);

    typedef enum logic {IDLE, COMMIT} state_t;

    state_t state;
    logic   vs_meta, vs_sync, vs_prev;
    logic   vs_fall;
    scene_t shadow, shadow_d;
    pos_t   atual, proxima;
    logic   passo_erro, idx_ok, cmd_erro, accept;

    assign accept   = CmdValid && CmdReady;
    assign idx_ok   = int'(CmdIndice) < NSPRITES;
    assign cmd_erro = passo_erro || !idx_ok;
    // VSync is active low: a commit starts when the synchronized value drops.
    assign vs_fall  = vs_prev && !vs_sync;

    // Current position of the addressed sprite (zero for an illegal index).
    always_comb begin
        atual = '0;
        for (int i = 0; i < NSPRITES; i++) begin
            if (CmdIndice == 3'(i)) atual = shadow[i];
        end
    end

    passo_sprite #(
        .NCOL (NCOL),
        .NROW (NROW)
    ) u_passo (
        .atual   (atual),
        .op      (op_t'(CmdOp)),
        .coluna  (CmdColuna),
        .linha   (CmdLinha),
        .proxima (proxima),
        .erro    (passo_erro)
    );

    // Shadow after this cycle's command; a commit on the same edge takes this
    // value, so a command accepted on the commit edge is never split off.
    always_comb begin
        shadow_d = shadow;
        for (int i = 0; i < NSPRITES; i++) begin
            if (accept && !cmd_erro && CmdIndice == 3'(i)) shadow_d[i] = proxima;
        end
    end

    // Two-flop synchronizer for VSync plus the edge-detect register.
    always_ff @(posedge Clock or negedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!Reset) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            vs_meta <= VSync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    // Commit FSM with registered outputs, shadow scene and command status.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state                           <= IDLE;
            CmdReady                        <= 1'b0;
            // NOTE: the shadow is a handful of flops, not a RAM, so it resets to the opening scene.
            shadow                          <= DEFAULT_SCENE;
            {ColunasSprites, LinhasSprites} <= pack_scene(DEFAULT_SCENE);
            Quadro                          <= 8'd0;
            Pendente                        <= 1'b0;
            Erro                            <= 1'b0;
        end else begin
            shadow <= shadow_d;
            Erro   <= accept && cmd_erro;
            if (accept && !cmd_erro) Pendente <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (vs_fall) begin
                        state                           <= COMMIT;
                        CmdReady                        <= 1'b0;
                        {ColunasSprites, LinhasSprites} <= pack_scene(shadow_d);
                        Quadro                          <= Quadro + 8'd1;
                        Pendente                        <= 1'b0;
                    end else begin
                        CmdReady <= 1'b1;
                    end
                end
                COMMIT: begin
                    state    <= IDLE;
                    CmdReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/controle_sprites.md
# controle_sprites

Holds the grid positions of the six game sprites (black cell, three trash items, robot, cursor) and drives the packed `ColunasSprites`/`LinhasSprites` buses consumed by `Grafico`. Game logic issues position commands through a valid/ready port. Accepted commands update a shadow copy. The shadow is committed to the outputs atomically once per frame, at the start of vertical sync from `Interface_VGA`, so a frame never shows a half-updated scene.

## Interface
Parameters:
- `NCOL`, 12: grid columns; legal column values are 0..NCOL-1.
- `NROW`, 8: grid rows; legal row values are 0..NROW-1.

Ports:
- `Clock`  in  1: 25 MHz pixel clock, the same clock as `Interface_VGA`.
- `Reset`  in  1: asynchronous, active-low reset.
- `VSync`  in  1: `v_sync` from `Interface_VGA`, active-low pulse.
- `CmdValid`  in  1: command present.
- `CmdReady`  out  1: block can accept a command this cycle.
- `CmdOp`  in  2: opcode. 00 = absolute write, 01 = relative step, 10 = hide, 11 = reserved.
- `CmdIndice`  in  3: sprite index. 0 = Cursor, 1 = Robo, 2 = Lixo3, 3 = Lixo2, 4 = Lixo1, 5 = CelulaPreta.
- `CmdColuna`  in  4: target column. For op 01, bits [1:0] carry the direction: 00 up, 01 down, 10 left, 11 right.
- `CmdLinha`  in  3: target row for op 00.
- `ColunasSprites`  out  24: committed columns, 4 bits per sprite. Sprite i occupies [4i+3:4i].
- `LinhasSprites`  out  18: committed rows, 3 bits per sprite. Sprite i occupies [3i+2:3i].
- `Quadro`  out  8: count of commits, wraps at 256.
- `Pendente`  out  1: the shadow holds at least one accepted write that is not yet committed.
- `Erro`  out  1: one-cycle pulse when a command is rejected or saturated.

## Operation
- Handshake: a command transfers on a rising edge where `CmdValid && CmdReady`. The bench may hold `CmdValid` high across cycles; each cycle with `CmdReady` high accepts a new command.
- Absolute write (op 00):
  - Sets shadow[i] to (CmdColuna, CmdLinha).
  - If column ≥ NCOL or row ≥ NROW: no change, `Erro` pulses.
- Relative step (op 01):
  - Moves shadow[i] by one cell in the requested direction.
  - At a grid edge, the position saturates (unchanged) and `Erro` pulses.
  - Stepping a hidden sprite: no change, `Erro` pulses.
- Hide (op 10): sets shadow column to 15, the off-grid sentinel; the row is unchanged. `Grafico` does not draw column 15.
- Reserved opcode (op 11), or index 6 or 7: no change, `Erro` pulses.
- Several writes per frame are allowed; the last write to a given sprite wins.
- A rejected command still counts as accepted (the handshake completes) and does not set `Pendente`.
- States:
  - IDLE → COMMIT on detection of a `VSync` falling edge.
  - COMMIT → IDLE unconditionally after one cycle.
- `VSync` edge detection: `VSync` passes through a 2-flop synchronizer, and the falling edge is detected on the synchronized value.
- Entering COMMIT:
  - Outputs load from the shadow.
  - `Quadro` increments.
  - `Pendente` clears.
- Reset, mid-operation or not, returns all state to the reset values below within the same cycle.

## Timing
- Reset values:
  - Shadow and outputs hold the default scene: CelulaPreta (1,5), Lixo1 (6,3), Lixo2 (10,5), Lixo3 (1,2), Robo (1,6), Cursor (6,3).
  - `ColunasSprites` = 24'h16A116, `LinhasSprites` = 18'h2BAB3.
  - `Quadro` = 0, `Pendente` = 0, `Erro` = 0.
  - `CmdReady` = 0 while `Reset` is low, and 1 from the first edge after release.
- Command latency: the shadow updates on the accepting edge. `Erro` and `Pendente` are valid in the following cycle.
- Commit latency: outputs change 3 cycles after `VSync` falls (2 synchronizer flops plus 1 edge-detect register).
- `CmdReady` is low for exactly the COMMIT cycle. No command is ever lost or split across a commit.
- The outputs are stable for a whole frame. They change only in COMMIT, during vertical sync, so `Grafico` never sees a change during active video.

## Structure
- Package `sprites_pkg` holds:
  - the sprite index constants 0..5;
  - the opcode and direction constants;
  - `HIDE_COL` = 15;
  - the default reset positions;
  - a function that packs the six positions into the 24-bit and 18-bit buses.
- Sub-module `passo_sprite` is purely combinational. It takes the current position, the opcode and the operands, and returns the next position plus an error flag. This isolates the saturation and range rules for unit testing.

## Test plan
- Reset release: `Reset` low for 3 cycles, then high. Required: `ColunasSprites` = 16A116h, `LinhasSprites` = 2BAB3h, `Quadro` = 0, `CmdReady` = 1 one cycle after release.
- Absolute write, index 1 to (3,4). Required:
  - Outputs stay unchanged and `Pendente` = 1 until `VSync` falls.
  - 3 cycles after `VSync` falls: `ColunasSprites[7:4]` = 3, `LinhasSprites[5:3]` = 4, `Quadro` = 1, `Pendente` = 0.
- Saturation: absolute write of index 0 to (11,0), then step right, then step up. Required: two `Erro` pulses, and committed Cursor = (11,0).
- Illegal commands: index 6, op 11, and absolute write of column 12. Required: 3 `Erro` pulses, no output change after the next commit, `Pendente` = 0.
- Collision with commit: hold `CmdValid` high continuously through a `VSync` fall. Required:
  - `CmdReady` is low for exactly 1 cycle.
  - Every command accepted before COMMIT appears in that frame; commands accepted after it appear in the next frame.
- Reset mid-frame: issue a write, then pulse `Reset` low before `VSync` falls. Required: the default scene is restored immediately, and the next commit still shows the defaults.
